// File: rtl/udpy_rr_evaluator_pkg.sv
// Purpose : shared constants and the reference Y function for the round-robin evaluator.
// Latency : n/a (package).
// Backpressure: n/a (package).
// Contents: NREQ/CNTW defaults, udpy_f(abcd) = A&~B&D | B&C&~D | A&C.
package udpy_pkg;

  localparam int NREQ = 4;
  localparam int CNTW = 8;

  // abcd is ordered {A,B,C,D} with A in bit 3.
  function automatic logic udpy_f(input logic [3:0] abcd);
    logic a, b, c, d;
    {a, b, c, d} = abcd;
    return (a & ~b & d) | (b & c & ~d) | (a & c);
  endfunction

endpackage

// File: rtl/udpy_rr_evaluator_if.sv
// Purpose : request/result bundle between requesters and the shared evaluator.
// Latency : n/a (wires only).
// Backpressure: none; requesters hold req/abcd until their gnt bit is seen.
// Ports   : req/abcd/clr driven by master, gnt/y_valid/y_out/y_id/ones_cnt/busy driven by slave.
interface udpy_rr_evaluator_if #(
  parameter int NREQ = 4,
  parameter int CNTW = 8
) ();
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] abcd;
  logic              clr;
  logic [NREQ-1:0]   gnt;
  logic              y_valid;
  logic              y_out;
  logic [IDW-1:0]    y_id;
  logic [CNTW-1:0]   ones_cnt;
  logic              busy;

  modport master (
    output req, abcd, clr,
    input  gnt, y_valid, y_out, y_id, ones_cnt, busy
  );

  modport slave (
    input  req, abcd, clr,
    output gnt, y_valid, y_out, y_id, ones_cnt, busy
  );
endinterface

// File: rtl/udpy_rr_evaluator_eval.sv
// Purpose : combinational Y = A&~B&D | B&C&~D | A&C on one 4-bit vector.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
// Ports   : abcd {A,B,C,D} in, y out.
module udpy_eval
  import udpy_pkg::*;
(
  input  logic [3:0] abcd,
  output logic       y
);
  assign y = udpy_f(abcd);
endmodule

// File: rtl/udpy_rr_evaluator.sv
// Purpose : round-robin arbiter feeding one shared Y evaluator, with saturating count of Y=1 results.
// Latency : 1 cycle from req/abcd sampled at an edge to registered gnt/y_valid/y_out/y_id.
// Backpressure: none; a requester simply stays asserted until it sees its gnt bit.
// Ports   : clk, rst_n (async active-low), bus (slave modport: req, abcd, clr -> gnt, y_valid, y_out, y_id, ones_cnt, busy).
module udpy_rr_evaluator
  import udpy_pkg::*;
#(
  parameter int NREQ = udpy_pkg::NREQ,
  parameter int CNTW = udpy_pkg::CNTW,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  udpy_rr_evaluator_if.slave   bus
);

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            y_valid_q, y_valid_d;
  logic            y_out_q, y_out_d;
  logic [IDW-1:0]  y_id_q, y_id_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            found;
  logic [IDW-1:0]  win_id;
  logic [3:0]      win_abcd;
  logic            win_y;

  // Rotating priority search: offset k from ptr, wrapped explicitly so
  // non-power-of-two NREQ never lands on a nonexistent index.
  always_comb begin
    int idx;
    found    = 1'b0;
    win_id   = '0;
    win_abcd = '0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found    = 1'b1;
        win_id   = IDW'(idx);
        win_abcd = bus.abcd[4*idx +: 4];
      end
    end
  end

  udpy_eval u_eval (
    .abcd (win_abcd),
    .y    (win_y)
  );

  always_comb begin
    gnt_d     = '0;
    y_valid_d = found;
    y_out_d   = y_out_q;
    y_id_d    = y_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (found) begin
      gnt_d[win_id] = 1'b1;
      y_out_d       = win_y;
      y_id_d        = win_id;
      ptr_d         = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
      if (win_y && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
    // Clear takes priority over a same-edge increment.
    if (bus.clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      gnt_q     <= '0;
      y_valid_q <= 1'b0;
      y_out_q   <= 1'b0;
      y_id_q    <= '0;
      cnt_q     <= '0;
    end else begin
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      y_valid_q <= y_valid_d;
      y_out_q   <= y_out_d;
      y_id_q    <= y_id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.y_valid  = y_valid_q;
  assign bus.y_out    = y_out_q;
  assign bus.y_id     = y_id_q;
  assign bus.ones_cnt = cnt_q;
  assign bus.busy     = |bus.req;

endmodule
